// File: rtl/multi_sample_en_if.sv
// Configuration and strobe bundle of multi_sample_en. The slave side is the generator;
// the master side is whoever programs it and consumes the strobes.
interface multi_sample_en_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16
);
    // No valid/ready pair here: RUN is a level, CFG_LOAD is a single-cycle pulse
    // that is always accepted, and the strobes cannot be back-pressured.
    logic                    RUN;
    logic                    CFG_LOAD;
    logic [N_CH*CNT_W-1:0]   PERIOD;
    logic [N_CH*CNT_W-1:0]   PHASE;
    logic [N_CH-1:0]         SAMPLE_EN;
    logic                    SYNC_OUT;
    logic                    READY;
    logic [2:0]              dbg_state;

    modport slave (
        input  RUN, CFG_LOAD, PERIOD, PHASE,
        output SAMPLE_EN, SYNC_OUT, READY, dbg_state
    );

    modport master (
        output RUN, CFG_LOAD, PERIOD, PHASE,
        input  SAMPLE_EN, SYNC_OUT, READY, dbg_state
    );
endinterface

// File: rtl/multi_sample_en.sv
// Multi-channel sample-strobe generator: qualifies PLL lock, then emits per-channel
// periodic one-cycle strobes with programmable phase and double-buffered period.
module multi_sample_en #(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 16,
    parameter int SETTLE = 1024
) (
    input  logic              CLK_100M,
    input  logic              CLK_RST,
    input  logic              LOCKED,
    multi_sample_en_if.slave  bus
);

    localparam int SET_W = (SETTLE > 2) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);
    localparam logic [SET_W-1:0] SETTLE_ONE  = SET_W'(1);

    localparam logic [2:0] ST_WAIT_LOCK = 3'd0;
    localparam logic [2:0] ST_SETTLE    = 3'd1;
    localparam logic [2:0] ST_IDLE      = 3'd2;
    localparam logic [2:0] ST_ARM       = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;

    logic [1:0]       lock_sync_q;
    logic             lock_s;
    logic [2:0]       state_q, state_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             ready_q, ready_d;
    logic             sync_q, sync_d;
    logic [N_CH-1:0]  strobe_q, strobe_d;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [CNT_W-1:0] sh_per_q [N_CH];
    logic [CNT_W-1:0] sh_per_d [N_CH];
    logic [CNT_W-1:0] sh_ph_q [N_CH];
    logic [CNT_W-1:0] sh_ph_d [N_CH];
    logic             arm_load;
    logic             run_stay;

    always_ff @(posedge CLK_100M or posedge CLK_RST) begin
        if (CLK_RST) begin
            lock_sync_q <= 2'b00;
        end else begin
            lock_sync_q <= {lock_sync_q[0], LOCKED};
        end
    end

    assign lock_s = lock_sync_q[1];

    // The WAIT_LOCK cycle that sees lock_s already counts toward the settle time.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        if (!lock_s) begin
            state_d  = ST_WAIT_LOCK;
            settle_d = '0;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    state_d  = ST_SETTLE;
                    settle_d = SETTLE_ONE;
                end
                ST_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (bus.RUN) begin
                        state_d = ST_ARM;
                    end
                end
                ST_ARM: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!bus.RUN) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_WAIT_LOCK;
                end
            endcase
        end
    end

    assign arm_load = (state_q == ST_ARM);
    assign run_stay = (state_q == ST_RUN) && (state_d == ST_RUN);

    always_comb begin
        ready_d = (state_d == ST_IDLE) || (state_d == ST_ARM) || (state_d == ST_RUN);
        sync_d  = arm_load && (state_d == ST_RUN);
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            if (bus.CFG_LOAD) begin
                sh_per_d[i] = bus.PERIOD[i*CNT_W +: CNT_W];
                sh_ph_d[i]  = bus.PHASE[i*CNT_W +: CNT_W];
            end else begin
                sh_per_d[i] = sh_per_q[i];
                sh_ph_d[i]  = sh_ph_q[i];
            end
        end
    end

    // A CFG_LOAD coinciding with ARM must seed the counters with the incoming phase.
    always_comb begin
        strobe_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (arm_load) begin
                cnt_d[i] = bus.CFG_LOAD ? bus.PHASE[i*CNT_W +: CNT_W] : sh_ph_q[i];
            end else if (run_stay) begin
                if (cnt_q[i] == '0) begin
                    strobe_d[i] = 1'b1;
                    cnt_d[i]    = sh_per_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK_100M or posedge CLK_RST) begin
        if (CLK_RST) begin
            state_q  <= ST_WAIT_LOCK;
            settle_q <= '0;
            ready_q  <= 1'b0;
            sync_q   <= 1'b0;
            strobe_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            ready_q  <= ready_d;
            sync_q   <= sync_d;
            strobe_q <= strobe_d;
        end
    end

    always_ff @(posedge CLK_100M or posedge CLK_RST) begin
        if (CLK_RST) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]    <= '0;
                sh_per_q[i] <= '1;
                sh_ph_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]    <= cnt_d[i];
                sh_per_q[i] <= sh_per_d[i];
                sh_ph_q[i]  <= sh_ph_d[i];
            end
        end
    end

    assign bus.SAMPLE_EN = strobe_q;
    assign bus.SYNC_OUT  = sync_q;
    assign bus.READY     = ready_q;
    assign bus.dbg_state = state_q;

endmodule
